cic_comp_fir_dec2: RTL and testbench

Decimate-by-2 CIC compensation FIR that consumes the 8-bit output stream of the three-stage CIC decimator. It buffers the CIC samples and uses one time-shared multiplier to evaluate a fixed 11-tap symmetric compensation filter on every second input sample. It produces rounded, saturated 8-bit results for the demodulator back end. It runs on one clock; the CIC output rate is signalled with a valid strobe.

---
 rtl/cic_comp_fir_dec2.sv | 140 ++++++++++++++
 tb/tb_cic_comp_fir_dec2.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_comp_fir_dec2.sv
// Decimate-by-2 CIC compensation FIR: 11-tap symmetric filter evaluated with one
// time-shared multiplier on every second CIC sample, rounded and saturated to 8 bits.
module cic_comp_fir_dec2 #(
    parameter int ACC_W     = 18,
    parameter int OUT_SHIFT = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] x_in,
    output logic [7:0] y_out,
    output logic       out_valid,
    output logic       busy,
    output logic       overrun
);

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [3:0] LAST_TAP = 4'd10;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] sample_buf [16];
    logic [3:0]               wr_ptr;
    logic [3:0]               base;
    logic [3:0]               tap;
    logic [3:0]               rd_addr;
    logic                     ph;
    logic                     trigger;
    logic                     start;
    logic                     mac_en;
    logic                     out_en;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;

    function automatic logic signed [COEF_W-1:0] coef(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd10: coef = -8'sd1;
            4'd2, 4'd8:  coef = 8'sd3;
            4'd3, 4'd7:  coef = -8'sd8;
            4'd4, 4'd6:  coef = 8'sd18;
            4'd5:        coef = 8'sd40;
            default:     coef = 8'sd0;
        endcase
    endfunction

    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] half;
        half = '0;
        half[OUT_SHIFT-1] = 1'b1;
        round_shift = (a + half) >>> OUT_SHIFT;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat8(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            sat8 = SAT_MAX[DATA_W-1:0];
        else if (v < SAT_MIN)
            sat8 = SAT_MIN[DATA_W-1:0];
        else
            sat8 = v[DATA_W-1:0];
    endfunction

    assign trigger  = in_valid & ph;
    assign rd_addr  = base - tap;
    assign prod     = PROD_W'(coef(tap)) * PROD_W'(sample_buf[rd_addr]);
    assign prod_ext = ACC_W'(prod);

    // Samples are stored in every state; the 5 writes that can land during a
    // computation sit ahead of base and never alias the 11 taps being read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++)
                sample_buf[i] <= '0;
            wr_ptr <= '0;
            ph     <= 1'b0;
        end else if (in_valid) begin
            sample_buf[wr_ptr] <= x_in;
            wr_ptr             <= wr_ptr + 4'd1;
            ph                 <= ~ph;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = MAC;
            MAC:     if (tap == LAST_TAP) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy stretches over the out_valid cycle so it covers the whole 13-cycle job.
    always_comb begin
        start  = (state == IDLE) && trigger;
        mac_en = (state == MAC);
        out_en = (state == OUT);
        busy   = (state != IDLE) || out_valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base      <= '0;
            tap       <= '0;
            acc       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (start) begin
                base <= wr_ptr;
                tap  <= '0;
                acc  <= '0;
            end else if (mac_en) begin
                acc <= acc + prod_ext;
                tap <= tap + 4'd1;
            end
            if (out_en)
                y_out <= sat8(round_shift(acc));
            out_valid <= out_en;
            if (trigger && (state != IDLE))
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cic_comp_fir_dec2.sv
// Bench for cic_comp_fir_dec2: reference filter model feeds a scoreboard of
// expected outputs/cycles; scenario tasks add explicit value checks.
module tb_cic_comp_fir_dec2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] x_in;
    logic [7:0] y_out;
    logic       out_valid;
    logic       busy;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [7:0] y;
        int         t;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    res_t e;

    int hc[11] = '{-1, 0, 3, -8, 18, 40, 18, -8, 3, 0, -1};

    logic signed [7:0] mbuf [16];
    int mptr      = 0;
    bit mph       = 1'b0;
    int last_trig = -1000;

    cic_comp_fir_dec2 #(.ACC_W(18), .OUT_SHIFT(6)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .in_valid (in_valid),
        .x_in     (x_in),
        .y_out    (y_out),
        .out_valid(out_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    function automatic res_t ref_fir(input int p, input int c);
        res_t r;
        int   a;
        int   q;
        a = 0;
        for (int i = 0; i < 11; i++)
            a += hc[i] * int'(mbuf[(p - i + 16) % 16]);
        q = (a + 32) >>> 6;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        r.y = q[7:0];
        r.t = c + 12;
        return r;
    endfunction

    // Reference model: samples inputs on the active edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mbuf[i] = '0;
            mptr      = 0;
            mph       = 1'b0;
            last_trig = -1000;
            exp_q.delete();
        end else if (in_valid) begin
            mbuf[mptr] = x_in;
            if (mph && (cyc - last_trig >= 13)) begin
                exp_q.push_back(ref_fir(mptr, cyc));
                last_trig = cyc;
            end
            mph  = ~mph;
            mptr = (mptr + 1) % 16;
        end
    end

    // Output monitor: pops the scoreboard whenever the DUT produces a result.
    always @(posedge clk) begin
        #1;
        if (busy) busy_cnt++;
        if (out_valid) begin
            obs_q.push_back('{y: y_out, t: cyc});
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got y=%0d at cycle %0d, required no output", $signed(y_out), cyc);
            end else begin
                e = exp_q.pop_front();
                if (y_out !== e.y || cyc != e.t) begin
                    failures++;
                    $display("FAIL sb_output: got y=%0d at cycle %0d, required y=%0d at cycle %0d",
                             $signed(y_out), cyc, $signed(e.y), e.t);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; x_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
    endtask

    // Called at a negedge; the next in_valid is gap cycles later.
    task automatic send(input int x, input int gap);
        in_valid = 1'b1;
        x_in     = 8'(x);
        @(negedge clk);
        in_valid = 1'b0;
        x_in     = 8'($urandom);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            x_in     = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({y_out, out_valid, busy, overrun} !== 11'b0) begin
                failures++;
                $display("FAIL reset_outputs: got y=%0d ov=%b busy=%b orun=%b, required all 0",
                         y_out, out_valid, busy, overrun);
            end
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        obs_q.delete();
        send(50, 20);
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_sample: got %0d outputs busy=%b, required 0 outputs busy=0", obs_q.size(), busy);
        end
    endtask

    task automatic test_latency();
        int b0, t0, want_busy;
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            b0 = busy_cnt;
            t0 = cyc + 1;
            send(int'($urandom_range(0, 255)), 20);
            want_busy = (n % 2 == 0) ? 13 : 0;
            checks++;
            if (busy_cnt - b0 != want_busy) begin
                failures++;
                $display("FAIL latency_busy sample %0d: got %0d busy cycles, required %0d", n, busy_cnt - b0, want_busy);
            end
            checks++;
            if (n % 2 == 0) begin
                if (obs_q.size() != 1 || obs_q[0].t - t0 != 12) begin
                    failures++;
                    $display("FAIL latency_out sample %0d: got %0d outputs latency %0d, required 1 output latency 12",
                             n, obs_q.size(), (obs_q.size() > 0) ? obs_q[0].t - t0 : -1);
                end
            end else if (obs_q.size() != 0) begin
                failures++;
                $display("FAIL latency_phase sample %0d: got %0d outputs, required 0", n, obs_q.size());
            end
            obs_q.delete();
        end
    endtask

    task automatic test_impulse(input bit with_reset, input int tag);
        int exp_imp[6] = '{0, -8, 40, -8, 0, 0};
        if (with_reset) do_reset();
        send(64, 8);
        for (int i = 0; i < 11; i++) send(0, 8);
        repeat (20) @(negedge clk);
        checks++;
        if (obs_q.size() != 6) begin
            failures++;
            $display("FAIL impulse_count run %0d: got %0d outputs, required 6", tag, obs_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs_q[i].y !== 8'(exp_imp[i])) begin
                    failures++;
                    $display("FAIL impulse_out run %0d idx %0d: got %0d, required %0d",
                             tag, i, $signed(obs_q[i].y), exp_imp[i]);
                end
            end
        end
    endtask

    task automatic test_dc();
        int lv[3] = '{100, 127, -128};
        foreach (lv[k]) begin
            do_reset();
            for (int i = 0; i < 16; i++) send(lv[k], 8);
            repeat (20) @(negedge clk);
            checks++;
            if (obs_q.size() != 8) begin
                failures++;
                $display("FAIL dc_count level %0d: got %0d outputs, required 8", lv[k], obs_q.size());
            end else begin
                for (int i = 5; i < 8; i++) begin
                    checks++;
                    if (obs_q[i].y !== 8'(lv[k])) begin
                        failures++;
                        $display("FAIL dc_out level %0d idx %0d: got %0d, required %0d",
                                 lv[k], i, $signed(obs_q[i].y), lv[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_saturation();
        int pv, nv, want, v;
        for (int s = 0; s < 2; s++) begin
            pv   = (s == 0) ? 127 : -128;
            nv   = (s == 0) ? -128 : 127;
            want = (s == 0) ? 127 : -128;
            do_reset();
            send(0, 8);
            for (int j = 0; j < 11; j++) begin
                v = (hc[10 - j] > 0) ? pv : (hc[10 - j] < 0) ? nv : 0;
                send(v, 8);
            end
            repeat (20) @(negedge clk);
            checks++;
            if (obs_q.size() != 6 || obs_q[obs_q.size() - 1].y !== 8'(want)) begin
                failures++;
                $display("FAIL saturation pattern %0d: got %0d outputs last=%0d, required 6 outputs last=%0d",
                         s, obs_q.size(), (obs_q.size() > 0) ? int'($signed(obs_q[obs_q.size() - 1].y)) : 0, want);
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send(10, 4);
        send(20, 4);
        send(30, 4);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_early: got %b, required 0", overrun);
        end
        send(40, 20);
        checks++;
        if (overrun !== 1'b1 || obs_q.size() != 1) begin
            failures++;
            $display("FAIL overrun_set: got overrun=%b outputs=%0d, required overrun=1 outputs=1", overrun, obs_q.size());
        end
        obs_q.delete();
        for (int i = 0; i < 4; i++) send(i * 7, 8);
        repeat (20) @(negedge clk);
        checks++;
        if (overrun !== 1'b1 || obs_q.size() != 2) begin
            failures++;
            $display("FAIL overrun_sticky: got overrun=%b outputs=%0d, required overrun=1 outputs=2", overrun, obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 2; s++) begin
            do_reset();
            send(11, 7);
            send(22, 6);
            send(33, (s == 0) ? 7 : 6);
            send(44, 20);
            checks++;
            if (s == 0 && (overrun !== 1'b0 || obs_q.size() != 2)) begin
                failures++;
                $display("FAIL spacing_13: got overrun=%b outputs=%0d, required overrun=0 outputs=2", overrun, obs_q.size());
            end else if (s == 1 && (overrun !== 1'b1 || obs_q.size() != 1)) begin
                failures++;
                $display("FAIL spacing_12: got overrun=%b outputs=%0d, required overrun=1 outputs=1", overrun, obs_q.size());
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        do_reset();
        send(5, 8);
        send(6, 5);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({y_out, out_valid, busy, overrun} !== 11'b0) begin
            failures++;
            $display("FAIL midmac_reset_outputs: got y=%0d ov=%b busy=%b orun=%b, required all 0",
                     y_out, out_valid, busy, overrun);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL midmac_no_output: got %0d outputs, required 0", obs_q.size());
        end
        test_impulse(1'b0, 2);
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        x_in     = '0;
        #2 rst_n = 1'b0;
        test_reset();
        test_latency();
        test_impulse(1'b1, 1);
        test_dc();
        test_saturation();
        test_overrun();
        test_back_to_back();
        test_reset_mid_mac();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_missing: got %0d expected outputs never produced, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
